// File: rtl/lenet_pkg.sv
// Shared LeNet datapath defaults and helpers. The helpers work on a wide signed
// type so any block whose data width is at most LENET_MAXW bits can reuse them.
package lenet_pkg;
  localparam int LENET_IN_WIDTH = 32;
  localparam int LENET_MAP_W    = 10;
  localparam int LENET_MAP_H    = 10;
  localparam int LENET_MAXW     = 64;

  typedef logic signed [LENET_MAXW-1:0] lenet_wide_t;

  function automatic lenet_wide_t relu(input lenet_wide_t x);
    return (x < 0) ? '0 : x;
  endfunction

  function automatic lenet_wide_t max2(input lenet_wide_t a, input lenet_wide_t b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/relu_maxpool22.sv
// ReLU followed by 2x2/stride-2 max pooling on a raster-order pixel stream.
// Horizontal pairs are reduced in r_h, vertical pairs through a half-width line buffer.
module relu_maxpool22
  import lenet_pkg::*;
#(
  parameter int IN_WIDTH = LENET_IN_WIDTH,  // must not exceed LENET_MAXW
  parameter int MAP_W    = LENET_MAP_W,
  parameter int MAP_H    = LENET_MAP_H
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic                       in_first,
  input  logic signed [IN_WIDTH-1:0] in_data,
  output logic                       out_valid,
  output logic signed [IN_WIDTH-1:0] out_data,
  output logic                       out_last
);
  localparam int CW = (MAP_W > 1) ? $clog2(MAP_W) : 1;
  localparam int RW = (MAP_H > 1) ? $clog2(MAP_H) : 1;
  localparam int HN = MAP_W / 2;
  localparam int HW = (HN > 1) ? $clog2(HN) : 1;

  logic [CW-1:0]                r_col;
  logic [RW-1:0]                r_row;
  logic signed [IN_WIDTH-1:0]   r_h;
  logic signed [IN_WIDTH-1:0]   r_lb [HN];
  logic                         r_out_valid;
  logic                         r_out_last;
  logic signed [IN_WIDTH-1:0]   r_out_data;

  logic [CW-1:0]                w_col;
  logic [RW-1:0]                w_row;
  logic [HW-1:0]                w_idx;
  logic signed [IN_WIDTH-1:0]   w_r;
  logic signed [IN_WIDTH-1:0]   w_p;
  logic signed [IN_WIDTH-1:0]   w_pool;
  logic                         w_col_end;
  logic                         w_row_end;
  logic                         w_emit;

  // in_first overrides the counters so a resync takes effect on this very pixel
  assign w_col     = in_first ? '0 : r_col;
  assign w_row     = in_first ? '0 : r_row;
  assign w_idx     = HW'(w_col >> 1);
  assign w_col_end = (w_col == CW'(MAP_W - 1));
  assign w_row_end = (w_row == RW'(MAP_H - 1));
  assign w_r       = IN_WIDTH'(relu(lenet_wide_t'(in_data)));
  assign w_p       = IN_WIDTH'(max2(lenet_wide_t'(r_h), lenet_wide_t'(w_r)));
  assign w_pool    = IN_WIDTH'(max2(lenet_wide_t'(r_lb[w_idx]), lenet_wide_t'(w_p)));
  assign w_emit    = in_valid && w_col[0] && w_row[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col       <= '0;
      r_row       <= '0;
      r_h         <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_out_valid <= w_emit;
      r_out_last  <= w_emit && w_col_end && w_row_end;
      if (w_emit) r_out_data <= w_pool;
      if (in_valid) begin
        if (!w_col[0]) r_h <= w_r;
        if (w_col_end) begin
          r_col <= '0;
          r_row <= w_row_end ? '0 : w_row + 1'b1;
        end else begin
          r_col <= w_col + 1'b1;
          r_row <= w_row;
        end
      end
    end
  end

  // Every entry is rewritten in an even row before the odd row reads it, so no reset
  always_ff @(posedge clk) begin
    if (in_valid && w_col[0] && !w_row[0]) r_lb[w_idx] <= w_p;
  end

  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_data  = r_out_data;
endmodule

// File: tb/tb_relu_maxpool22.sv
// Randomized and directed bench for relu_maxpool22 against a whole-map pooling model.
module tb_relu_maxpool22;
  localparam int W  = 32;
  localparam int MW = 10;
  localparam int MH = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_first = 1'b0;
  logic signed [W-1:0] in_data = '0;
  logic out_valid;
  logic out_last;
  logic signed [W-1:0] out_data;

  relu_maxpool22 #(.IN_WIDTH(W), .MAP_W(MW), .MAP_H(MH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [W-1:0] d;
    bit                  last;
    int                  due;
  } exp_t;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  exp_t q[$];
  logic signed [W-1:0] got[$];
  int lastidx[$];
  logic signed [W-1:0] pix [MH][MW];
  logic signed [W-1:0] hold = '0;
  int mcol = 0;
  int mrow = 0;

  function automatic logic signed [W-1:0] mx(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: store the post-ReLU map and pool each 2x2 window when its last pixel lands
  always @(posedge clk) begin
    logic signed [W-1:0] rv;
    exp_t e;
    cyc++;
    if (rst) begin
      mcol = 0; mrow = 0; q.delete(); hold = '0;
    end else if (in_valid) begin
      if (in_first) begin mcol = 0; mrow = 0; end
      rv = (in_data < 0) ? '0 : in_data;
      pix[mrow][mcol] = rv;
      if ((mrow % 2 == 1) && (mcol % 2 == 1)) begin
        e.d    = mx(mx(pix[mrow-1][mcol-1], pix[mrow-1][mcol]), mx(pix[mrow][mcol-1], rv));
        e.last = (mrow == MH-1) && (mcol == MW-1);
        e.due  = cyc;
        q.push_back(e);
      end
      mcol++;
      if (mcol == MW) begin
        mcol = 0; mrow++;
        if (mrow == MH) mrow = 0;
      end
    end
  end

  always @(negedge clk) begin
    bit ev;
    if (rst) begin
      check("reset_valid", out_valid, 0);
      check("reset_last", out_last, 0);
      check("reset_data", out_data, 0);
    end else begin
      while (q.size() > 0 && q[0].due < cyc) begin
        check("missed_output", 0, q[0].d);
        void'(q.pop_front());
      end
      ev = (q.size() > 0) && (q[0].due == cyc);
      check("out_valid", out_valid, ev);
      if (ev && out_valid) begin
        check("out_data", out_data, q[0].d);
        check("out_last", out_last, q[0].last);
        hold = q[0].d;
        void'(q.pop_front());
      end else if (!out_valid) begin
        check("idle_last", out_last, 0);
        check("idle_hold", out_data, hold);
      end
      if (out_valid) begin
        got.push_back(out_data);
        if (out_last) lastidx.push_back(got.size() - 1);
      end
    end
  end

  task automatic send_px(input logic signed [W-1:0] d, input bit first, input int gap);
    in_valid = 1'b1; in_first = first; in_data = d;
    @(posedge clk); #1;
    in_valid = 1'b0; in_first = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  // mode 0 ramp(+off), 1 relu pattern, 2 random data; gap<0 means random gaps;
  // stop_at limits the map to pixels before linear index stop_at
  task automatic send_map(input int mode, input int off, input int gap, input int stop_at);
    logic signed [W-1:0] d;
    int g;
    for (int r = 0; r < MH; r++)
      for (int c = 0; c < MW; c++) begin
        if (r*MW + c < stop_at) begin
          case (mode)
            0: d = r*10 + c + off;
            1: d = (r == 3 && c == 3) ? 7 : -5;
            default: d = $urandom;
          endcase
          g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
          send_px(d, (r == 0 && c == 0), g);
        end
      end
  endtask

  task automatic drain();
    repeat (4) begin @(posedge clk); #1; end
  endtask

  task automatic clear_log();
    got.delete(); lastidx.delete();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // ramp, continuous
    clear_log();
    send_map(0, 0, 0, MH*MW); drain();
    check("ramp_count", got.size(), 25);
    if (got.size() == 25) begin
      check("ramp_first", got[0], 11);
      check("ramp_5th", got[4], 19);
      check("ramp_6th", got[5], 31);
      check("ramp_last", got[24], 99);
    end
    check("ramp_nlast", lastidx.size(), 1);
    if (lastidx.size() == 1) check("ramp_last_idx", lastidx[0], 24);

    // ReLU pattern
    clear_log();
    send_map(1, 0, 0, MH*MW); drain();
    check("relu_count", got.size(), 25);
    if (got.size() == 25) begin
      check("relu_11", got[6], 7);
      check("relu_00", got[0], 0);
    end

    // gaps 1,0,0
    clear_log();
    send_map(0, 0, 2, MH*MW); drain();
    check("gap_count", got.size(), 25);
    if (got.size() == 25) check("gap_last", got[24], 99);

    // resync at (4,6)
    clear_log();
    send_map(0, 0, 0, 4*MW + 6);
    send_map(0, 0, 0, MH*MW); drain();
    check("resync_count", got.size(), 35);
    if (got.size() == 35) check("resync_new_first", got[10], 11);

    // reset after pixel (5,2)
    clear_log();
    send_map(0, 0, 0, 5*MW + 3);
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    send_map(0, 0, 0, MH*MW); drain();
    check("rst_count", got.size(), 36);
    if (got.size() == 36) check("rst_new_first", got[11], 11);

    // back-to-back
    clear_log();
    send_map(0, 0, 0, MH*MW);
    send_map(0, 100, 0, MH*MW); drain();
    check("b2b_count", got.size(), 50);
    if (got.size() == 50) check("b2b_second_first", got[25], 111);
    check("b2b_nlast", lastidx.size(), 2);
    if (lastidx.size() == 2) begin
      check("b2b_last0", lastidx[0], 24);
      check("b2b_last1", lastidx[1], 49);
    end

    // random data and gaps
    repeat (4) send_map(2, 0, -1, MH*MW);
    drain();
    check("queue_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/relu_maxpool22.md
RELU_MAXPOOL22 -- requirements
Module: relu_maxpool22

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 32, meaning the signed width of the convolution value and of the pooled output.
REQ-002 SHALL have parameter MAP_W, default 10, meaning the input feature-map width; even, >=2.
REQ-003 SHALL have parameter MAP_H, default 10, meaning the input feature-map height; even, >=2.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-006 SHALL have port in_valid, input, 1, meaning in_data carries one conv-stage output pixel this cycle.
REQ-007 SHALL have port in_first, input, 1, meaning this pixel is row 0 / column 0 of a new map; sampled only when in_valid=1.
REQ-008 SHALL have port in_data, input, IN_WIDTH, signed convolution value (bias already added).
REQ-009 SHALL have port out_valid, output, 1, one-cycle qualifier for out_data.
REQ-010 SHALL have port out_data, output, IN_WIDTH, signed pooled value, always >=0.
REQ-011 SHALL have port out_last, output, 1, high with out_valid on the final pooled pixel of a map.

Function
REQ-012 SHALL accept pixels in raster order (column fastest); gaps of any length between in_valid cycles SHALL be allowed, with no backpressure.
REQ-013 SHALL apply ReLU to every accepted pixel: r = (in_data<0) ? 0 : in_data.
REQ-014 SHALL track col (0..MAP_W-1) and row (0..MAP_H-1) counters, advanced only on in_valid; col wraps to 0 and increments row; row wraps to 0 after MAP_H-1.
REQ-015 SHALL, on in_valid with in_first=1, treat that pixel as (0,0) regardless of counter state, discarding any partial map (resync).
REQ-016 SHALL, at even col, hold r in a horizontal register h.
REQ-017 SHALL, at odd col, form p = max(h, r).
REQ-018 SHALL, at odd col of an even row, write p into line-buffer entry col>>1 (MAP_W/2 entries of IN_WIDTH bits).
REQ-019 SHALL, at odd col of an odd row, register out_data = max(linebuf[col>>1], p) and assert out_valid the following cycle (latency exactly 1 cycle from the accepting edge).
REQ-020 SHALL assert out_last together with out_valid when the triggering pixel is (MAP_H-1, MAP_W-1).
REQ-021 SHALL hold out_valid and out_last low in all other cycles; out_data SHALL hold its last value when out_valid=0.
REQ-022 SHALL emit exactly (MAP_W/2)*(MAP_H/2) outputs per complete map, in pooled raster order.
REQ-023 SHALL compare as signed values; no saturation or truncation; out_data width equals IN_WIDTH.
REQ-024 SHALL support back-to-back maps with no idle cycle between the last pixel of one map and the first of the next.

Reset
REQ-025 SHALL, while rst=1, force out_valid=0, out_last=0, out_data=0, col=0, row=0, h=0.
REQ-026 SHALL NOT require line-buffer reset; every entry is written in an even row before it is read in the next odd row.
REQ-027 SHALL, when rst asserts mid-map, abandon the map; the first in_valid after release is pixel (0,0).

Structure
REQ-028 SHALL take IN_WIDTH and map-size defaults, and the relu/max2 functions, from shared package lenet_pkg.
REQ-029 SHALL be a single module with no sub-module; the line buffer is an internal register array.

Verification
REQ-030 SHALL cover ramp: a 10x10 map with in_data = row*10+col, continuous -> 25 outputs 11,13,15,17,19,31,...,99; out_last only on the 25th.
REQ-031 SHALL cover ReLU: all pixels -5 except (3,3)=7 -> output (1,1)=7, the other 24 outputs 0.
REQ-032 SHALL cover gaps: the same ramp with in_valid toggling 1,0,0 -> identical outputs, each exactly 1 cycle after its triggering pixel.
REQ-033 SHALL cover resync: in_first=1 asserted at pixel (4,6), followed by a full map -> no output from the partial map until the new map's row 1 col 1 completes; 25 correct outputs follow.
REQ-034 SHALL cover reset mid-map: rst pulsed after pixel (5,2), then a full ramp map -> outputs match the ramp expectation, with no stale values.
REQ-035 SHALL cover back-to-back: two ramp maps, the second offset by +100, with no gap -> 50 outputs; out_last on the 25th and 50th; the second map's first output is 111.
